decode_issue_stage: RTL
=======================

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter N, default 16: instruction width; N SHALL be at least 16, and only bits [15:0] are decoded.
REQ-002 Parameter NREG, default 16: register count; register index width is clog2(NREG), fixed at 4 for NREG=16.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  fetch-side handshake.
REQ-006 instruction  input  N  instruction word from fetch.
REQ-007 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-008 flush  input  1  drop the held instruction (taken jump).
REQ-009 wb_valid / wb_reg  input / input  1 / 4  writeback retire; clears the pending bit of wb_reg.
REQ-010 MemoryWrite, writeMemFrom, OverWriteNz, RegWriteEnSc, RegWriteEnVec  output  1 each  registered decode flags.
REQ-011 WriteRegFrom 2, RegToWrite 4, Immediate 8, PcWriteEn 3, AluOpCode 3  output  registered decode fields.
REQ-012 busy_regs  output  NREG  scoreboard of pending register writes.

Function
REQ-013 Combinational decode SHALL use the ASIP 16-bit encoding. Bit 15 = 0 is ALU; [15:14] = 10 is jump; [15:14] = 11 is memory. The fields are dest [11:8], imm [7:0], rs1 [7:4] and rs2 [3:0].
REQ-014 Vector destinations are dest[3:2] = 00 (registers 0-3); all other destinations are scalar.
REQ-015 Sources checked for hazards: rs1 and rs2 for ALU ops with AluOpCode ≠ 000; rs1 for memory ops; dest also for stores (MemoryWrite = 1). Jumps check no sources.
REQ-016 Hazard = any checked source has its busy_regs bit set, OR the instruction writes a dest whose busy bit is set (WAW).
REQ-017 in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-018 Capture on in_valid & in_ready: decoded fields SHALL be registered and out_valid set to 1. Latency is exactly 1 cycle.
REQ-019 On capture of a register-writing instruction, busy_regs[dest] SHALL be set in the same edge.
REQ-020 out_valid & ~out_ready: all outputs SHALL hold stable.
REQ-021 out_valid & out_ready with no capture: out_valid SHALL clear next cycle.
REQ-022 wb_valid SHALL clear busy_regs[wb_reg] on the next edge.
REQ-023 When set and clear hit the same register in one cycle, set SHALL win.
REQ-024 flush SHALL clear out_valid.
REQ-025 On flush, if the held instruction writes a register, its busy bit SHALL be cleared. WAW stalling guarantees no older write is outstanding on that register.
REQ-026 flush has priority over capture; no instruction is accepted in a flush cycle.
REQ-027 Hazard re-evaluation SHALL use the registered busy_regs, so a retire frees a stalled instruction one cycle later.

Reset
REQ-028 While rst_n = 0, out_valid = 0, busy_regs = 0, all decode outputs = 0 and in_ready = 0, asynchronously.
REQ-029 After rst_n rises, in_ready = 1 from the first edge. In-flight state is discarded on reset mid-operation.

Structure
REQ-030 Package asip_decode_pkg SHALL hold: the opcode class enum (ALU, JUMP, MEM), the field bit-position constants, the WriteRegFrom encodings (ALU, IMM, MEM, PC) and the vector-register-range constant.
REQ-031 A combinational sub-module decode_fields SHALL produce all decode flags from instruction[15:0].
REQ-032 decode_issue_stage SHALL own the pipeline register, handshake and scoreboard.

Verification
REQ-033 Reset then 0x1320 with out_ready = 1 -> next cycle: out_valid = 1, RegToWrite = 3, RegWriteEnVec = 1, busy_regs = 0x0008.
REQ-034 RAW: 0x1520 then 0x1650 (rs1 = 5) -> in_ready = 0 until wb_valid with wb_reg = 5; capture occurs 1 cycle after busy_regs[5] clears.
REQ-035 Backpressure: out_ready = 0 for 3 cycles -> outputs unchanged, in_ready = 0; release -> next instruction captured on the same edge.
REQ-036 Flush while holding 0x1720 -> out_valid = 0 next edge, busy_regs[7] = 0, and the flush-cycle in_valid is not accepted.
REQ-037 Same-cycle retire of R4 and capture of 0x1420 -> busy_regs[4] = 1. Assert rst_n = 0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/asip_decode_pkg.sv
// ---------------------------------------------------------------------------
// asip_decode_pkg
// Shared definitions for the ASIP 16-bit decode/issue stage:
//   - opcode class enum (ALU, JUMP, MEM)
//   - instruction field bit positions
//   - WriteRegFrom encodings (ALU, IMM, MEM, PC)
//   - PcWriteEn encodings
//   - vector register range and a helper to classify a destination
//   - decode_t: the bundle of decoded fields passed from decode_fields to
//     the issue stage and held in its pipeline register
// ---------------------------------------------------------------------------
package asip_decode_pkg;

    typedef enum logic [1:0] {
        OPC_ALU  = 2'd0,
        OPC_JUMP = 2'd1,
        OPC_MEM  = 2'd2
    } op_class_e;

    // Field bit positions within instruction[15:0]
    localparam int CLASS_BIT    = 15;  // 0 = ALU
    localparam int SUBCLASS_BIT = 14;  // with CLASS_BIT = 1: 0 = jump, 1 = memory
    localparam int ALUOP_HI     = 14;
    localparam int ALUOP_LO     = 12;
    localparam int JCOND_HI     = 13;
    localparam int JCOND_LO     = 12;
    localparam int STORE_BIT    = 13;
    localparam int MEMSRC_BIT   = 12;
    localparam int DEST_HI      = 11;
    localparam int DEST_LO      = 8;
    localparam int IMM_HI       = 7;
    localparam int IMM_LO       = 0;
    localparam int RS1_HI       = 7;
    localparam int RS1_LO       = 4;
    localparam int RS2_HI       = 3;
    localparam int RS2_LO       = 0;

    // WriteRegFrom encodings
    localparam logic [1:0] WRF_ALU = 2'd0;
    localparam logic [1:0] WRF_IMM = 2'd1;
    localparam logic [1:0] WRF_MEM = 2'd2;
    localparam logic [1:0] WRF_PC  = 2'd3;

    // PcWriteEn encodings (one-hot jump kind)
    localparam logic [2:0] PCW_NONE = 3'b000;
    localparam logic [2:0] PCW_JMP  = 3'b001;
    localparam logic [2:0] PCW_JZ   = 3'b010;
    localparam logic [2:0] PCW_JNZ  = 3'b100;

    // Vector registers are 0-3: dest[3:2] == VEC_SEL
    localparam logic [1:0] VEC_SEL = 2'b00;

    function automatic logic is_vec_reg(input logic [3:0] r);
        return (r[3:2] == VEC_SEL);
    endfunction

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] imm;
        logic [2:0] alu_op;
        logic [2:0] pc_we;
        logic [1:0] wr_from;
        logic       mem_wr;
        logic       mem_from;
        logic       ow_nz;
        logic       we_sc;
        logic       we_vec;
        logic       use_rs1;
        logic       use_rs2;
        logic       chk_dest;   // dest read as a source (store) or written (WAW)
    } decode_t;

endpackage

// File: rtl/decode_fields.sv
// ---------------------------------------------------------------------------
// decode_fields
// Purely combinational decode of one ASIP 16-bit instruction.
// Ports:
//   instr  in  16         instruction bits [15:0]
//   dec    out decode_t   decoded flags, fields and hazard-source selects
// Encoding summary:
//   ALU  (bit15 = 0):   [14:12] AluOpCode. 000 loads imm into dest,
//                       others compute dest <= rs1 op rs2 and update N/Z.
//   JUMP ([15:14] = 10): [13:12] 00 jmp, 01 jz, 10 jnz, 11 jmp-and-link
//                       (link writes PC into dest).
//   MEM  ([15:14] = 11): bit13 = 1 store (mem[rs1] <= dest or imm,
//                       bit12 selects imm), bit13 = 0 load dest <= mem[rs1].
// ---------------------------------------------------------------------------
module decode_fields
    import asip_decode_pkg::*;
(
    input  logic [15:0] instr,
    output decode_t     dec
);

    op_class_e  op_class;
    logic       writes_reg;

    always_comb begin
        if (!instr[CLASS_BIT])
            op_class = OPC_ALU;
        else if (!instr[SUBCLASS_BIT])
            op_class = OPC_JUMP;
        else
            op_class = OPC_MEM;
    end

    always_comb begin
        dec          = '0;
        writes_reg   = 1'b0;
        dec.dest     = instr[DEST_HI:DEST_LO];
        dec.rs1      = instr[RS1_HI:RS1_LO];
        dec.rs2      = instr[RS2_HI:RS2_LO];
        dec.imm      = instr[IMM_HI:IMM_LO];

        case (op_class)
            OPC_ALU: begin
                dec.alu_op = instr[ALUOP_HI:ALUOP_LO];
                writes_reg = 1'b1;
                if (dec.alu_op == 3'b000) begin
                    dec.wr_from = WRF_IMM;
                end else begin
                    dec.wr_from = WRF_ALU;
                    dec.ow_nz   = 1'b1;
                    dec.use_rs1 = 1'b1;
                    dec.use_rs2 = 1'b1;
                end
            end
            OPC_JUMP: begin
                case (instr[JCOND_HI:JCOND_LO])
                    2'b01:   dec.pc_we = PCW_JZ;
                    2'b10:   dec.pc_we = PCW_JNZ;
                    default: dec.pc_we = PCW_JMP;
                endcase
                // Link variant saves the return PC into dest.
                if (instr[JCOND_HI:JCOND_LO] == 2'b11) begin
                    writes_reg  = 1'b1;
                    dec.wr_from = WRF_PC;
                end
            end
            default: begin
                dec.use_rs1 = 1'b1;
                if (instr[STORE_BIT]) begin
                    dec.mem_wr   = 1'b1;
                    dec.mem_from = instr[MEMSRC_BIT];
                end else begin
                    writes_reg  = 1'b1;
                    dec.wr_from = WRF_MEM;
                end
            end
        endcase

        dec.we_vec   = writes_reg & is_vec_reg(dec.dest);
        dec.we_sc    = writes_reg & ~is_vec_reg(dec.dest);
        // Stores read dest; writers must not overtake a pending write (WAW).
        dec.chk_dest = writes_reg | dec.mem_wr;
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ---------------------------------------------------------------------------
// decode_issue_stage
// Decodes the fetched instruction, stalls on register hazards using a
// pending-write scoreboard, and holds the decoded result in a single
// pipeline register for the execute stage.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        fetch-side handshake
//   instruction [N-1:0]        fetched word, bits [15:0] decoded
//   out_valid / out_ready      execute-side handshake
//   flush                      drop the held instruction (taken jump)
//   wb_valid / wb_reg [3:0]    writeback retire, frees busy_regs[wb_reg]
//   MemoryWrite, writeMemFrom, OverWriteNz, RegWriteEnSc, RegWriteEnVec,
//   WriteRegFrom[1:0], RegToWrite[3:0], Immediate[7:0], PcWriteEn[2:0],
//   AluOpCode[2:0]             registered decode outputs
//   busy_regs [NREG-1:0]       scoreboard of pending register writes
// ---------------------------------------------------------------------------
module decode_issue_stage
    import asip_decode_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    instruction,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [3:0]      wb_reg,
    output logic            MemoryWrite,
    output logic            writeMemFrom,
    output logic            OverWriteNz,
    output logic            RegWriteEnSc,
    output logic            RegWriteEnVec,
    output logic [1:0]      WriteRegFrom,
    output logic [3:0]      RegToWrite,
    output logic [7:0]      Immediate,
    output logic [2:0]      PcWriteEn,
    output logic [2:0]      AluOpCode,
    output logic [NREG-1:0] busy_regs
);

    decode_t         dec_p0;
    decode_t         dec_p1;
    logic            vld_p1;
    logic [NREG-1:0] busy_p1;
    logic [NREG-1:0] busy_nxt;
    logic            hazard_p0;
    logic            capture_p0;
    logic            held_writes_p1;

    // ---- stage p0: combinational decode and hazard check ----
    decode_fields u_decode_fields (
        .instr (instruction[15:0]),
        .dec   (dec_p0)
    );

    // Uses the registered scoreboard only, so a retire frees a stalled
    // instruction one cycle after wb_valid.
    always_comb begin
        hazard_p0 = (dec_p0.use_rs1  & busy_p1[dec_p0.rs1])
                  | (dec_p0.use_rs2  & busy_p1[dec_p0.rs2])
                  | (dec_p0.chk_dest & busy_p1[dec_p0.dest]);
    end

    // rst_n gating keeps in_ready low while reset is asserted.
    assign in_ready   = rst_n & (~vld_p1 | out_ready) & ~hazard_p0 & ~flush;
    assign capture_p0 = in_valid & in_ready;

    assign held_writes_p1 = vld_p1 & (dec_p1.we_sc | dec_p1.we_vec);

    // Order matters: clears first, then the capture set so set wins.
    always_comb begin
        busy_nxt = busy_p1;
        if (wb_valid)
            busy_nxt[wb_reg] = 1'b0;
        // WAW stalling guarantees no older write to this dest is pending.
        if (flush && held_writes_p1)
            busy_nxt[dec_p1.dest] = 1'b0;
        if (capture_p0 && (dec_p0.we_sc || dec_p0.we_vec))
            busy_nxt[dec_p0.dest] = 1'b1;
    end

    // ---- stage p1: pipeline register and scoreboard ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            dec_p1  <= '0;
            busy_p1 <= '0;
        end else begin
            busy_p1 <= busy_nxt;
            if (flush)
                vld_p1 <= 1'b0;
            else if (capture_p0)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;
            if (capture_p0)
                dec_p1 <= dec_p0;
        end
    end

    assign out_valid     = vld_p1;
    assign busy_regs     = busy_p1;
    assign MemoryWrite   = dec_p1.mem_wr;
    assign writeMemFrom  = dec_p1.mem_from;
    assign OverWriteNz   = dec_p1.ow_nz;
    assign RegWriteEnSc  = dec_p1.we_sc;
    assign RegWriteEnVec = dec_p1.we_vec;
    assign WriteRegFrom  = dec_p1.wr_from;
    assign RegToWrite    = dec_p1.dest;
    assign Immediate     = dec_p1.imm;
    assign PcWriteEn     = dec_p1.pc_we;
    assign AluOpCode     = dec_p1.alu_op;

endmodule
